// File: rtl/issue_hazard_ctrl.sv
// In-order issue controller: holds back instructions whose sources are still in flight
// in the non-forwarding datapath, issuing NOP bubbles (32'h0) until the result lands.
//
// state | meaning
// IDLE  | nothing presented, scoreboard empty
// RUN   | issuing instructions without hazard
// STALL | presented instruction blocked by a RAW hazard, bubbles issued
// DRAIN | no instruction presented, in-flight writes still retiring
module issue_hazard_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 5,
  parameter int INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [INSTR_W-1:0] issue_instr,
  output logic               issue_valid,
  output logic [15:0]        stall_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [PIPE_DEPTH-1:0] sb_v;
  logic [REG_AW-1:0]     sb_rd [PIPE_DEPTH];

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rd, rs, rt;
  logic              is_nop, r_type, writes;
  logic              rs_hit, rt_hit, hazard, accept, sb_empty;

  assign opcode = instr_in[INSTR_W-1 -: 6];
  assign rd     = instr_in[21 +: REG_AW];
  assign rs     = instr_in[16 +: REG_AW];
  assign rt     = instr_in[11 +: REG_AW];
  assign is_nop = (opcode == 6'd0);
  assign r_type = !opcode[3];
  assign writes = !is_nop && (rd != '0);

  // Every slot is compared, including the one about to shift out this cycle.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_v[i] && (sb_rd[i] == rs)) rs_hit = 1'b1;
      if (sb_v[i] && (sb_rd[i] == rt)) rt_hit = 1'b1;
    end
  end

  assign hazard      = instr_valid && !is_nop &&
                       (((rs != '0) && rs_hit) || (r_type && (rt != '0) && rt_hit));
  assign instr_ready = !rst && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign sb_empty    = (sb_v == '0);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      sb_v     <= {sb_v[PIPE_DEPTH-2:0], accept && writes};
      sb_rd[0] <= rd;
      for (int i = 1; i < PIPE_DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_instr <= '0;
      issue_valid <= 1'b0;
      stall_count <= '0;
      state       <= IDLE;
    end else begin
      issue_instr <= accept ? instr_in : '0;
      issue_valid <= accept && !is_nop;
      if (hazard && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      state       <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (instr_valid) state_nxt = hazard ? STALL : RUN;
      end
      RUN: begin
        if (hazard)            state_nxt = STALL;
        else if (!instr_valid) state_nxt = sb_empty ? IDLE : DRAIN;
      end
      STALL: begin
        if (!hazard && instr_valid) state_nxt = RUN;
        else if (!instr_valid)      state_nxt = sb_empty ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (instr_valid)   state_nxt = hazard ? STALL : RUN;
        else if (sb_empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
